// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/allowin inter-stage pipeline buffer with flush and optional perf counters
//   Optional feature macro: PIPE_STAGE_BUF_PERF_EN (builds perf_stall / perf_full counters)
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   up_valid/up_allowin/up_data     upstream handshake and payload
//   head_ready_go    head entry finished its multi-cycle work
//   dn_valid/dn_allowin/dn_data     downstream handshake and head payload
//   flush            synchronous kill of all held entries
//   count            occupied entries, 0..DEPTH
//   perf_clr, perf_stall, perf_full performance counter clear and values
module pipe_stage_buf #(
    parameter int DW = 64,
    parameter int DEPTH = 1,
    parameter int ALLOWIN_CHAIN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_allowin,
    input  logic [DW-1:0] up_data,
    input  logic          head_ready_go,
    output logic          dn_valid,
    input  logic          dn_allowin,
    output logic [DW-1:0] dn_data,
    input  logic          flush,
    output logic [2:0]    count,
    input  logic          perf_clr,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_full
);
    logic [DW-1:0] mem [DEPTH];
    logic [1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic up_fire, dn_fire;

    assign dn_valid = (count != 3'd0) && head_ready_go;
    assign dn_fire = dn_valid && dn_allowin;
    // chained allowin lets a full buffer take a new entry into the slot being read out
    assign up_allowin = (count < 3'(DEPTH)) || (ALLOWIN_CHAIN != 0 && dn_fire);
    assign up_fire = up_valid && up_allowin;
    // explicit wrap so non-power-of-2 depths cycle through exactly DEPTH slots
    assign wr_nxt = (wr_ptr == 2'(DEPTH - 1)) ? 2'd0 : wr_ptr + 2'd1;
    assign rd_nxt = (rd_ptr == 2'(DEPTH - 1)) ? 2'd0 : rd_ptr + 2'd1;

    always_comb begin
        dn_data = mem[0];
        for (int i = 1; i < DEPTH; i++)
            if (rd_ptr == 2'(i)) dn_data = mem[i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (up_fire) begin
                for (int i = 0; i < DEPTH; i++)
                    if (wr_ptr == 2'(i)) mem[i] <= up_data;
                wr_ptr <= wr_nxt;
            end
            if (dn_fire) rd_ptr <= rd_nxt;
            count <= count + 3'(up_fire) - 3'(dn_fire);
        end
    end

`ifdef PIPE_STAGE_BUF_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            perf_stall <= '0;
            perf_full <= '0;
        end else begin
            if (count != 3'd0 && !dn_fire && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
            if (count == 3'(DEPTH) && perf_full != '1) perf_full <= perf_full + 32'd1;
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign perf_stall = '0;
    assign perf_full = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf at DEPTH 1/2/3
module tb_pipe_stage_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic uv[3], ua[3], hrg[3], dv[3], da[3], fl[3], pc[3];
    logic [15:0] ud[3], dd[3];
    logic [2:0] cnt[3];
    logic [31:0] ps[3], pf[3];
    int checks = 0;
    int failures = 0;
`ifdef PIPE_STAGE_BUF_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pipe_stage_buf #(
            .DW(16),
            .DEPTH(g + 1),
            .ALLOWIN_CHAIN(g == 1 ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .up_valid(uv[g]), .up_allowin(ua[g]), .up_data(ud[g]),
            .head_ready_go(hrg[g]),
            .dn_valid(dv[g]), .dn_allowin(da[g]), .dn_data(dd[g]),
            .flush(fl[g]), .count(cnt[g]),
            .perf_clr(pc[g]), .perf_stall(ps[g]), .perf_full(pf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt, got, mc;
        logic [39:0] pat;
        for (int k = 0; k < 3; k++) begin
            uv[k] = 0; ud[k] = '0; hrg[k] = 1; da[k] = 0; fl[k] = 0; pc[k] = 0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_count", 32'(cnt[k]), 0);
            chk("rst_dn_valid", 32'(dv[k]), 0);
            chk("rst_up_allowin", 32'(ua[k]), 1);
            chk("rst_dn_data", 32'(dd[k]), 0);
            chk("rst_perf_stall", ps[k], 0);
        end
        rst_n = 1;
        tick();

        // T1: depth 1 with chained allowin streams one item per cycle
        da[0] = 1;
        for (int k = 1; k <= 4; k++) begin
            uv[0] = 1; ud[0] = 16'(k);
            #1;
            chk("t1_up_allowin", 32'(ua[0]), 1);
            if (k > 1) begin
                chk("t1_dn_data", 32'(dd[0]), 32'(k - 1));
                chk("t1_count", 32'(cnt[0]), 1);
                chk("t1_dn_valid", 32'(dv[0]), 1);
            end
            tick();
        end
        uv[0] = 0;
        #1;
        chk("t1_last_data", 32'(dd[0]), 4);
        tick();
        chk("t1_empty", 32'(cnt[0]), 0);
        da[0] = 0;

        // T2: depth 2, unchained: full blocks C even while a read happens
        uv[1] = 1; ud[1] = 16'hA;
        #1; chk("t2_allow_a", 32'(ua[1]), 1);
        tick();
        ud[1] = 16'hB;
        #1; chk("t2_count1", 32'(cnt[1]), 1);
        tick();
        ud[1] = 16'hC;
        #1;
        chk("t2_full_count", 32'(cnt[1]), 2);
        chk("t2_full_allowin", 32'(ua[1]), 0);
        chk("t2_head_a", 32'(dd[1]), 32'hA);
        tick();
        chk("t2_c_rejected", 32'(cnt[1]), 2);
        da[1] = 1;
        #1;
        chk("t2_nochain_allowin", 32'(ua[1]), 0);
        chk("t2_out_a", 32'(dd[1]), 32'hA);
        tick();
        chk("t2_out_b", 32'(dd[1]), 32'hB);
        chk("t2_allow_c", 32'(ua[1]), 1);
        tick();
        uv[1] = 0;
        #1;
        chk("t2_out_c", 32'(dd[1]), 32'hC);
        chk("t2_count_c", 32'(cnt[1]), 1);
        tick();
        chk("t2_empty", 32'(cnt[1]), 0);
        da[1] = 0;

        // T3: depth 3, 7 items under a toggling downstream
        nxt = 1; got = 1; mc = 0;
        pat = 40'hFF_FFDB_6D70;
        for (int c = 0; c < 40 && got <= 7; c++) begin
            uv[2] = (nxt <= 7); ud[2] = 16'(nxt); da[2] = pat[c];
            #1;
            chk("t3_count", 32'(cnt[2]), 32'(mc));
            chk("t3_dn_valid", 32'(dv[2]), 32'(mc != 0));
            chk("t3_allowin", 32'(ua[2]), 32'((mc < 3) || (mc != 0 && da[2])));
            if (dv[2] && da[2]) begin
                chk("t3_order", 32'(dd[2]), 32'(got));
                got++;
                mc--;
            end
            if (uv[2] && ua[2]) begin
                nxt++;
                mc++;
            end
            tick();
        end
        chk("t3_done", 32'(got), 8);
        uv[2] = 0; da[2] = 0;

        // T4: head held by a multi-cycle unit while later entries fill up
        uv[2] = 1; ud[2] = 16'h55; hrg[2] = 0; da[2] = 1; pc[2] = 1;
        tick();
        pc[2] = 0;
        for (int s = 1; s <= 5; s++) begin
            ud[2] = (s == 1) ? 16'h66 : (s == 2) ? 16'h77 : 16'h88;
            #1;
            chk("t4_held", 32'(dv[2]), 0);
            chk("t4_allowin", 32'(ua[2]), 32'(s < 3));
            tick();
        end
        chk("t4_count", 32'(cnt[2]), 3);
        uv[2] = 0; hrg[2] = 1;
        #1;
        chk("t4_release", 32'(dv[2]), 1);
        chk("t4_head", 32'(dd[2]), 32'h55);
        chk("t4_perf_stall", ps[2], PERF ? 32'd5 : 32'd0);
        chk("t4_perf_full", pf[2], PERF ? 32'd3 : 32'd0);
        tick();
        chk("t4_second", 32'(dd[2]), 32'h66);
        tick();
        chk("t4_third", 32'(dd[2]), 32'h77);
        tick();
        chk("t4_empty", 32'(cnt[2]), 0);
        da[2] = 0;

        // T5: flush with a simultaneous write drops everything
        uv[2] = 1; ud[2] = 16'h11;
        tick();
        ud[2] = 16'h22;
        tick();
        ud[2] = 16'h33; fl[2] = 1;
        #1;
        chk("t5_pre_count", 32'(cnt[2]), 2);
        chk("t5_pre_allowin", 32'(ua[2]), 1);
        tick();
        uv[2] = 0; fl[2] = 0;
        #1;
        chk("t5_count", 32'(cnt[2]), 0);
        chk("t5_dn_valid", 32'(dv[2]), 0);
        chk("t5_allowin", 32'(ua[2]), 1);
        uv[2] = 1; ud[2] = 16'h44;
        tick();
        uv[2] = 0; da[2] = 1;
        #1;
        chk("t5_next_data", 32'(dd[2]), 32'h44);
        chk("t5_next_count", 32'(cnt[2]), 1);
        tick();
        da[2] = 0;

        // T6: mid-cycle reset pulse is ignored, edge-sampled reset clears
        uv[1] = 1; ud[1] = 16'h9;
        tick();
        ud[1] = 16'h8;
        tick();
        uv[1] = 0;
        rst_n = 0;
        #2;
        rst_n = 1;
        tick();
        chk("t6_glitch_count", 32'(cnt[1]), 2);
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        chk("t6_count", 32'(cnt[1]), 0);
        chk("t6_dn_data", 32'(dd[1]), 0);
        chk("t6_allowin", 32'(ua[1]), 1);
        chk("t6_perf_stall", ps[2], 0);
        chk("t6_perf_full", pf[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
